pixel_stream_transmitter: RTL

Source end of the pixel interface consumed by `buffered_matrix_colorspace_converter`. Accepts 24-bit RGB pixels from an upstream writer (host or frame-memory reader) into a small synchronous FIFO. Re-emits them as a paced, raster-ordered stream with one-clock pixel strobes at the pixel-clock rate, plus row and frame markers and horizontal blanking. Sits directly in front of the colorspace converter in the edge-detection datapath.

---
 rtl/colorspace_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/pixel_stream_transmitter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/colorspace_pkg.sv
// Shared types for the edge-detection pixel datapath: RGB pixel layout,
// transmitter state encoding and a counter-width helper.
package colorspace_pkg;

  localparam int PIXEL_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2
  } tx_state_t;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and show-ahead read data.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_transmitter.sv
// Buffers upstream RGB pixels and re-emits them as a paced raster stream with
// one-clock strobes, frame/row markers and horizontal blanking slots.
module pixel_stream_transmitter
  import colorspace_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 16,
  parameter int PIXEL_DIV    = 4,
  parameter int HBLANK_SLOTS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIXEL_W-1:0]            in_pixel,
  output logic                          out_valid,
  output logic [PIXEL_W-1:0]            out_pixel,
  output logic                          out_start_of_frame,
  output logic                          out_end_of_row,
  output logic                          out_end_of_frame,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underflow
);

  localparam int DIV_W = cnt_width(PIXEL_DIV);
  localparam int COL_W = cnt_width(IMAGE_WIDTH);
  localparam int ROW_W = cnt_width(IMAGE_HEIGHT);
  localparam int BLK_W = cnt_width(HBLANK_SLOTS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HBLANK_SLOTS - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [BLK_W-1:0] r_blank, w_blank_nxt;

  logic             r_out_valid, w_valid_nxt;
  pixel_rgb_t       r_out_pixel, w_pixel_nxt;
  logic             r_sof, w_sof_nxt;
  logic             r_eor, w_eor_nxt;
  logic             r_eof, w_eof_nxt;
  logic             r_underflow, w_underflow_nxt;

  pixel_rgb_t       w_fifo_data;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  logic             w_tick;

  sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (in_valid),
    .i_wr_data (in_pixel),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_count   (w_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Full is exactly count == FIFO_DEPTH, so this is count < FIFO_DEPTH.
  assign in_ready = !w_fifo_full;
  assign w_tick   = enable && (r_state != IDLE) && (r_div == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_blank     <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_sof       <= 1'b0;
      r_eor       <= 1'b0;
      r_eof       <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_blank     <= w_blank_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_pixel <= w_pixel_nxt;
      r_sof       <= w_sof_nxt;
      r_eor       <= w_eor_nxt;
      r_eof       <= w_eof_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_blank_nxt     = r_blank;
    w_pop           = 1'b0;
    w_valid_nxt     = 1'b0;
    w_pixel_nxt     = r_out_pixel;
    w_sof_nxt       = 1'b0;
    w_eor_nxt       = 1'b0;
    w_eof_nxt       = 1'b0;
    w_underflow_nxt = r_underflow;

    if (enable && (r_state != IDLE)) begin
      w_div_nxt = w_tick ? '0 : r_div + 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        w_div_nxt   = '0;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
        w_blank_nxt = '0;
        if (enable && !w_fifo_empty) w_state_nxt = ACTIVE;
      end

      ACTIVE: begin
        if (w_tick) begin
          if (w_fifo_empty) begin
            // Slot missed: position is kept so the next tick retries it.
            w_underflow_nxt = 1'b1;
          end else begin
            w_pop       = 1'b1;
            w_valid_nxt = 1'b1;
            w_pixel_nxt = w_fifo_data;
            w_sof_nxt   = (r_col == '0) && (r_row == '0);
            if (r_col == COL_LAST) begin
              w_eor_nxt = 1'b1;
              w_col_nxt = '0;
              if (r_row == ROW_LAST) begin
                w_eof_nxt   = 1'b1;
                w_row_nxt   = '0;
                w_state_nxt = IDLE;
              end else begin
                w_row_nxt   = r_row + 1'b1;
                w_blank_nxt = '0;
                w_state_nxt = HBLANK;
              end
            end else begin
              w_col_nxt = r_col + 1'b1;
            end
          end
        end
      end

      HBLANK: begin
        if (w_tick) begin
          if (r_blank == BLK_LAST) begin
            w_blank_nxt = '0;
            w_state_nxt = ACTIVE;
          end else begin
            w_blank_nxt = r_blank + 1'b1;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_valid          = r_out_valid;
  assign out_pixel          = r_out_pixel;
  assign out_start_of_frame = r_sof;
  assign out_end_of_row     = r_eor;
  assign out_end_of_frame   = r_eof;
  assign fifo_count         = w_fifo_count;
  assign underflow          = r_underflow;

endmodule
